arc_seq_alu: RTL
================

# arc_seq_alu

Multi-cycle ALU for the mARC datapath. It sits directly upstream of the processor status register. It executes one arithmetic, logic or shift operation per start request and returns a registered result. It produces the 4-bit condition flags (V, C, Z, N) together with a one-cycle write strobe that drives the PSR `rw` and `flags` inputs. Shifts run iteratively, one bit per cycle, so the block uses a start/busy/done handshake with the control unit.

## Interface
- `WIDTH`, 32, operand/result width (≥ 8)
- `SHAMT_W`, 5, shift-amount width; the amount is `b[SHAMT_W-1:0]`
- `clk` input 1 system clock, rising edge
- `reset` input 1 synchronous, active-high reset
- `start` input 1 request; sampled only in IDLE
- `op` input 3 opcode: 000 AND, 001 OR, 010 ORN, 011 ADD, 100 SRL, 101 SLL, 110 SRA, 111 SUB
- `set_cc` input 1 update flags on completion (the `cc` suffix ops)
- `a` input WIDTH operand A
- `b` input WIDTH operand B / shift amount
- `busy` output 1 high in SHIFT and DONE
- `done` output 1 one-cycle completion pulse
- `result` output WIDTH registered result, held until next completion
- `flags` output 4 {V,C,Z,N}, held until next flag-updating completion; feeds PSR `flags`
- `flags_we` output 1 pulses with `done` when `set_cc`=1; feeds PSR `rw`

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE + `start`:
  - Latch `op` and `set_cc`.
  - For AND, OR, ORN, ADD or SUB: compute, register `result` and pending flags → DONE.
  - For a shift with amount n>0: load the shift register with `a` and the counter with n → SHIFT.
  - For a shift with n=0: `result`=`a` → DONE.
- SHIFT: shift one bit per cycle and decrement the counter.
  - When the counter reaches 1, the final shift completes → DONE.
  - SRL fills with 0, SLL fills with 0, SRA replicates the MSB.
- DONE: assert `done` for one cycle. If `set_cc`, also assert `flags_we` and update `flags`. Then → IDLE.
- Flag rules:
  - N = result[WIDTH-1]
  - Z = (result==0)
  - ADD: C = carry out of bit WIDTH-1; V = signed overflow (both operand signs equal and different from result sign)
  - SUB: computed as a + ~b + 1; C = borrow (inverse of carry out); V = signed overflow of a-b
  - Logic ops: V=0, C=0
  - Shifts: V=0; C = last bit shifted out, or 0 when n=0
- Arithmetic wraps modulo 2^WIDTH.
- `start` while `busy` is ignored and produces no effect. No queueing.
- Flags update only on a `set_cc` completion. A non-cc completion leaves `flags` unchanged.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `flags_we`=0, `result`=0, `flags`=4'b0000.
- Reset asserted mid-operation aborts it. No `done` is issued for the aborted op.
- Latency, counted from the rising edge sampling `start` to the edge where `done` is high:
  - Non-shift ops and zero-amount shifts: `done` is high in the cycle after the `start` edge (latency 1).
  - Shift of n: `done` is high n+1 cycles after the `start` edge.
- `result`, `flags` and `flags_we` are valid in the same cycle as `done`. The PSR captures them on the next rising edge.
- Earliest back-to-back start: the cycle after `done`, i.e. `start` is sampled in IDLE. The minimum issue interval is 2 cycles.

## Configuration
- `ALU_SUBCC_EN`
  - Defined: op 111 is SUB as described above.
  - Undefined: op 111 is a NOP. It completes with latency 1 and `result`=`a`; `flags_we` stays 0 and `flags` are unchanged regardless of `set_cc`.

## Structure
- Shared package `arc_alu_pkg`:
  - opcode constants `ALU_AND`…`ALU_SUB`
  - FSM state encoding
  - flag bit indices `FLAG_V`=3, `FLAG_C`=2, `FLAG_Z`=1, `FLAG_N`=0, matching PSR bit order
- One sub-module, `alu_flag_gen`: combinational; takes the result, carry, overflow and op class, and returns {V,C,Z,N}. It is instantiated once.

## Test plan
- Reset mid-SRL (a=32'hFFFF_FFFF, amount 20, reset at cycle 5) → no `done`; `busy`=0, `result`=0, `flags`=0 on the next cycle.
- ADDcc, a=32'h7FFF_FFFF, b=1 → `done` one cycle after start; `result`=32'h8000_0000, flags=4'b1001 (V=1, N=1), `flags_we`=1.
- ADDcc, a=32'hFFFF_FFFF, b=1 → `result`=0, flags=4'b0110 (C=1, Z=1). Then ORN (no cc) with a=0, b=32'hFFFF_FFFF → `result`=0, `flags_we`=0, flags still 4'b0110.
- SRAcc, a=32'h8000_0001, b=4 → `done` exactly 5 cycles after start; `result`=32'hF800_0000, flags=4'b0001 (C=0, N=1). A `start` pulsed during SHIFT is ignored.
- SLLcc, a=32'h8000_0000, b=0 → latency 1, `result`=32'h8000_0000, flags=4'b0001. Then SLLcc, a=32'h8000_0000, b=1 → `result`=0, flags=4'b0110.
- SUBcc, a=5, b=7, with `ALU_SUBCC_EN` defined → `result`=32'hFFFF_FFFE, flags=4'b0101 (C=borrow, N=1). With the macro undefined → `result`=5, `flags_we`=0.

Source files
------------

// File: rtl/arc_alu_pkg.sv
// Shared definitions for the mARC sequential ALU: opcodes, FSM states,
// operation classes and PSR flag bit positions.
package arc_alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ORN = 3'b010,
    ALU_ADD = 3'b011,
    ALU_SRL = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRA = 3'b110,
    ALU_SUB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_e;

  typedef enum logic [1:0] {
    CLS_LOGIC,
    CLS_ARITH,
    CLS_SHIFT
  } op_class_e;

  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SRL) || (op == ALU_SLL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/arc_seq_alu_if.sv
// Control-unit <-> ALU handshake and data bus.
interface arc_seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             set_cc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             flags_we;

  modport master (
    output start, op, set_cc, a, b,
    input  busy, done, result, flags, flags_we
  );

  modport slave (
    input  start, op, set_cc, a, b,
    output busy, done, result, flags, flags_we
  );
endinterface

// File: rtl/alu_flag_gen.sv
// Combinational {V,C,Z,N} generator for the sequential ALU.
module alu_flag_gen
  import arc_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  input  op_class_e        op_class,
  output logic [3:0]       flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    case (op_class)
      CLS_ARITH: begin
        flags[FLAG_V] = overflow;
        flags[FLAG_C] = carry;
      end
      CLS_SHIFT: flags[FLAG_C] = carry;
      default:   ;
    endcase
  end

endmodule

// File: rtl/arc_seq_alu.sv
// Multi-cycle ALU with iterative 1-bit-per-cycle shifter and PSR flag strobe.
// Optional feature macro: ALU_SUBCC_EN (op 111 is SUB; otherwise a NOP).
module arc_seq_alu
  import arc_alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input logic          clk,
  input logic          reset,
  arc_seq_alu_if.slave bus
);

  alu_state_e       state;
  alu_op_e          op_q;
  logic             cc_q;
  logic [WIDTH-1:0] sr;
  logic [SHAMT_W-1:0] cnt;

  logic             busy_q, done_q, flags_we_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  alu_op_e          op_in;
  logic             cc_in;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] fin_result;
  logic             fin_carry, fin_ovf;
  op_class_e        fin_cls;
  logic [3:0]       fin_flags;

  assign op_in = alu_op_e'(bus.op);
  assign shamt = bus.b[SHAMT_W-1:0];

`ifdef ALU_SUBCC_EN
  assign cc_in = bus.set_cc;
`else
  assign cc_in = bus.set_cc && (op_in != ALU_SUB);
`endif

  // fin_* describes whatever completes on this edge: the last shift step
  // while in SHIFT, otherwise the single-cycle op presented in IDLE.
  always_comb begin
    sum        = '0;
    sr_next    = sr;
    fin_result = '0;
    fin_carry  = 1'b0;
    fin_ovf    = 1'b0;
    fin_cls    = CLS_LOGIC;
    if (state == ST_SHIFT) begin
      fin_cls = CLS_SHIFT;
      case (op_q)
        ALU_SLL: begin
          sr_next   = {sr[WIDTH-2:0], 1'b0};
          fin_carry = sr[WIDTH-1];
        end
        ALU_SRA: begin
          sr_next   = {sr[WIDTH-1], sr[WIDTH-1:1]};
          fin_carry = sr[0];
        end
        default: begin
          sr_next   = {1'b0, sr[WIDTH-1:1]};
          fin_carry = sr[0];
        end
      endcase
      fin_result = sr_next;
    end else begin
      case (op_in)
        ALU_AND: fin_result = bus.a & bus.b;
        ALU_OR:  fin_result = bus.a | bus.b;
        ALU_ORN: fin_result = bus.a | ~bus.b;
        ALU_ADD: begin
          sum        = {1'b0, bus.a} + {1'b0, bus.b};
          fin_result = sum[WIDTH-1:0];
          fin_carry  = sum[WIDTH];
          fin_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                       (sum[WIDTH-1] != bus.a[WIDTH-1]);
          fin_cls    = CLS_ARITH;
        end
`ifdef ALU_SUBCC_EN
        ALU_SUB: begin
          sum        = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
          fin_result = sum[WIDTH-1:0];
          fin_carry  = ~sum[WIDTH];
          fin_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                       (sum[WIDTH-1] != bus.a[WIDTH-1]);
          fin_cls    = CLS_ARITH;
        end
`else
        ALU_SUB: fin_result = bus.a;
`endif
        default: begin
          // zero-amount shift: pass-through, no bit shifted out
          fin_result = bus.a;
          fin_cls    = CLS_SHIFT;
        end
      endcase
    end
  end

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .result   (fin_result),
    .carry    (fin_carry),
    .overflow (fin_ovf),
    .op_class (fin_cls),
    .flags    (fin_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= ALU_AND;
      cc_q       <= 1'b0;
      sr         <= '0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      flags_we_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      flags_we_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q <= op_in;
            cc_q <= cc_in;
            if (is_shift(op_in) && (shamt != '0)) begin
              sr     <= bus.a;
              cnt    <= shamt;
              busy_q <= 1'b1;
              state  <= ST_SHIFT;
            end else begin
              result_q   <= fin_result;
              done_q     <= 1'b1;
              busy_q     <= 1'b1;
              flags_we_q <= cc_in;
              if (cc_in) flags_q <= fin_flags;
              state <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            result_q   <= fin_result;
            done_q     <= 1'b1;
            flags_we_q <= cc_q;
            if (cc_q) flags_q <= fin_flags;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.flags    = flags_q;
  assign bus.flags_we = flags_we_q;

endmodule
